// File: rtl/i2c_target_byte_if.sv
// I2C target responder: oversampled START/STOP detection, fixed 7-bit address match,
// and byte-wide write/read handshakes with local logic. SDA is open-drain (0 or z only).
module i2c_target_byte_if #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det,
    output logic       master_nack
);

    localparam int unsigned CNT_W    = 3;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(7);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_prev, sda_prev;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_c, stop_c;

    logic [7:0]       shift_q, shift_d, shift_in;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             rw_q, rw_d;
    logic             ack_phase_q, ack_phase_d;
    logic             ack_ok_q, ack_ok_d;
    logic             sda_oe_q, sda_oe_d;
    logic [7:0]       rx_data_d;
    logic             rx_valid_d, tx_req_d, addressed_d;
    logic             start_det_d, stop_det_d, master_nack_d;

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    // Bus synchronizers; reset to the idle-high bus level so release causes no false edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign start_c  = scl_s & sda_prev & ~sda_s;
    assign stop_c   = scl_s & ~sda_prev & sda_s;
    assign shift_in = {shift_q[6:0], sda_s};

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            ack_ok_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            addressed   <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            master_nack <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            ack_ok_q    <= ack_ok_d;
            sda_oe_q    <= sda_oe_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            tx_req      <= tx_req_d;
            addressed   <= addressed_d;
            start_det   <= start_det_d;
            stop_det    <= stop_det_d;
            master_nack <= master_nack_d;
        end
    end

    // Next-state logic; START/STOP override any SCL edge in the same cycle
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = ADDR;
        end else if (stop_c) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      state_d = IDLE;
                ADDR:
                    if (scl_rise && bit_cnt_q == BIT_LAST)
                        state_d = (shift_in[7:1] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK:
                    if (scl_fall && ack_phase_q) state_d = rw_q ? READ : WRITE;
                WRITE:
                    if (scl_rise && bit_cnt_q == BIT_LAST) state_d = WRITE_ACK;
                WRITE_ACK:
                    if (scl_fall && ack_phase_q) state_d = ack_ok_q ? WRITE : IGNORE;
                READ:
                    if (scl_fall && bit_cnt_q == BIT_LAST) state_d = READ_ACK;
                READ_ACK:
                    if (scl_rise && sda_s)             state_d = IGNORE;
                    else if (scl_fall && ack_phase_q)  state_d = READ;
                IGNORE:    state_d = IGNORE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        rw_d          = rw_q;
        ack_phase_d   = ack_phase_q;
        ack_ok_d      = ack_ok_q;
        sda_oe_d      = sda_oe_q;
        rx_data_d     = rx_data;
        addressed_d   = addressed;
        rx_valid_d    = 1'b0;
        tx_req_d      = 1'b0;
        start_det_d   = 1'b0;
        stop_det_d    = 1'b0;
        master_nack_d = 1'b0;

        if (start_c) begin
            start_det_d = 1'b1;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
        end else if (stop_c) begin
            stop_det_d  = 1'b1;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
        end else if (tx_req) begin
            // tx_data is captured on the cycle tx_req is visible to the core
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ADDR:
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            rw_d        = sda_s;
                            ack_phase_d = 1'b0;
                        end
                    end
                ADDR_ACK:
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            addressed_d = 1'b1;
                            bit_cnt_d   = '0;
                            tx_req_d    = rw_q;
                        end
                    end
                WRITE:
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            ack_ok_d    = rx_ready;
                            ack_phase_d = 1'b0;
                            if (rx_ready) begin
                                rx_data_d  = shift_in;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end
                WRITE_ACK:
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = ack_ok_q;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = '0;
                        end
                    end
                READ:
                    if (scl_fall) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            sda_oe_d    = 1'b0;
                            ack_phase_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                READ_ACK:
                    if (scl_rise) begin
                        if (sda_s) master_nack_d = 1'b1;
                        else       ack_phase_d   = 1'b1;
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = '0;
                        tx_req_d    = 1'b1;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_byte_if.sv
// Bench for i2c_target_byte_if: bit-banged I2C master on an open-drain bus with
// scoreboard queues for received and transmitted bytes.
module tb_i2c_target_byte_if;

    localparam int Q = 20;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_oe;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       addressed;
    logic       start_det;
    logic       stop_det;
    logic       master_nack;

    int n_cmp = 0;
    int n_err = 0;
    int n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0, n_mnack = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target_byte_if #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl         (scl),
        .sda         (sda),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .addressed   (addressed),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .master_nack (master_nack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Output monitor: pulses counted per cycle high, received bytes scored in order
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                n_rxv++;
                if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (tx_req)      n_txr++;
            if (start_det)   n_start++;
            if (master_nack) n_mnack++;
            if (stop_det) begin
                n_stop++;
                check("addressed_at_stop", 32'(addressed), 32'd0);
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; wait_q();
        scl  = 1'b1; wait_q();
        m_oe = 1'b1; wait_q();
        scl  = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; wait_q();
        scl  = 1'b1; wait_q();
        m_oe = 1'b0; wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic got);
        m_oe = ~b;   wait_q();
        scl  = 1'b1; wait_q();
        got  = sda;  wait_q();
        scl  = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], g);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, g);
            b[i] = g;
        end
        bus_bit(mack, g);
    endtask

    task automatic check_read(input string tag, input logic mack);
        logic [7:0] b;
        read_byte(mack, b);
        if (exp_tx.size() == 0) check({tag, "_unexpected"}, 32'(b), 32'hFFFF_FFFF);
        else                    check(tag, 32'(b), 32'(exp_tx.pop_front()));
    endtask

    initial begin
        logic ack, g;
        int   s_rxv, s_txr, s_start, s_stop, s_mnack;

        reset    = 1'b1;
        scl      = 1'b1;
        m_oe     = 1'b0;
        rx_ready = 1'b1;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_rx_data",   32'(rx_data),   32'h0);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_addressed", 32'(addressed), 32'h0);
        check("rst_sda",       32'(sda),       32'h1);
        check("rst_pulses", 32'({tx_req, start_det, stop_det, master_nack}), 32'h0);
        reset = 1'b0;
        wait_q();

        // Write 0xA5 to the matching address
        s_rxv = n_rxv; s_stop = n_stop; s_start = n_start;
        bus_start();
        write_byte(8'h84, ack);  check("t1_addr_ack", 32'(ack), 32'd0);
        check("t1_addressed", 32'(addressed), 32'd1);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack);  check("t1_data_ack", 32'(ack), 32'd0);
        bus_stop();
        check("t1_rx_count",   32'(n_rxv - s_rxv),     32'd1);
        check("t1_start",      32'(n_start - s_start), 32'd1);
        check("t1_stop",       32'(n_stop - s_stop),   32'd1);
        check("t1_addr_after", 32'(addressed),         32'd0);

        // Foreign address is never acknowledged
        s_rxv = n_rxv; s_stop = n_stop;
        bus_start();
        write_byte(8'h86, ack);  check("t2_addr_nack", 32'(ack), 32'd1);
        write_byte(8'hFF, ack);  check("t2_data_nack", 32'(ack), 32'd1);
        check("t2_addressed", 32'(addressed), 32'd0);
        bus_stop();
        check("t2_rx_count", 32'(n_rxv - s_rxv), 32'd0);
        check("t2_stop",     32'(n_stop - s_stop), 32'd1);

        // Two-byte read, master ACKs first and NACKs second
        s_txr = n_txr; s_mnack = n_mnack; s_rxv = n_rxv;
        tx_data = 8'h3C; exp_tx.push_back(8'h3C);
        bus_start();
        write_byte(8'h85, ack);  check("t3_addr_ack", 32'(ack), 32'd0);
        tx_data = 8'hC3; exp_tx.push_back(8'hC3);
        check_read("t3_byte1", 1'b0);
        check_read("t3_byte2", 1'b1);
        bus_stop();
        check("t3_tx_req",     32'(n_txr - s_txr),     32'd2);
        check("t3_mnack",      32'(n_mnack - s_mnack), 32'd1);
        check("t3_rx_count",   32'(n_rxv - s_rxv),     32'd0);

        // Core back-pressure: second byte NACKed, third ignored
        s_rxv = n_rxv;
        rx_ready = 1'b1;
        bus_start();
        write_byte(8'h84, ack);  check("t4_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack);  check("t4_ack1", 32'(ack), 32'd0);
        rx_ready = 1'b0;
        write_byte(8'h22, ack);  check("t4_nack2", 32'(ack), 32'd1);
        rx_ready = 1'b1;
        write_byte(8'h33, ack);  check("t4_ign3", 32'(ack), 32'd1);
        bus_stop();
        check("t4_rx_count", 32'(n_rxv - s_rxv), 32'd1);

        // Write then repeated START into a one-byte read
        s_rxv = n_rxv; s_start = n_start; s_txr = n_txr; s_mnack = n_mnack;
        bus_start();
        write_byte(8'h84, ack);  check("t5_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h10);
        write_byte(8'h10, ack);  check("t5_data_ack", 32'(ack), 32'd0);
        tx_data = 8'h5A; exp_tx.push_back(8'h5A);
        bus_start();
        write_byte(8'h85, ack);  check("t5_raddr_ack", 32'(ack), 32'd0);
        check("t5_addressed", 32'(addressed), 32'd1);
        check_read("t5_read", 1'b1);
        bus_stop();
        check("t5_start",    32'(n_start - s_start), 32'd2);
        check("t5_rx_count", 32'(n_rxv - s_rxv),     32'd1);
        check("t5_tx_req",   32'(n_txr - s_txr),     32'd1);
        check("t5_mnack",    32'(n_mnack - s_mnack), 32'd1);

        // Reset while the address ACK is being driven
        s_rxv = n_rxv;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(i == 7 || i == 2, g);
        m_oe = 1'b0; wait_q();
        scl  = 1'b1; wait_q();
        check("t6_ack_low", 32'(sda), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_sda_released", 32'(sda), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_q();
        scl = 1'b0; wait_q();
        write_byte(8'h84, ack);  check("t6_ignored_a", 32'(ack), 32'd1);
        write_byte(8'h55, ack);  check("t6_ignored_b", 32'(ack), 32'd1);
        check("t6_addressed", 32'(addressed), 32'd0);
        bus_stop();
        bus_start();
        write_byte(8'h84, ack);  check("t6_recover_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h77);
        write_byte(8'h77, ack);  check("t6_data_ack", 32'(ack), 32'd0);
        bus_stop();
        check("t6_rx_count", 32'(n_rxv - s_rxv), 32'd1);

        wait_q();
        check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
